// File: rtl/btn_edge_pkg.sv
// rtl/btn_edge_pkg.sv - shared defaults, hold-phase encoding and width helpers
package btn_edge_pkg;

    localparam int CH_NUM_DEF        = 4;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int DB_CYCLES_DEF     = 20;
    localparam int LONG_CYCLES_DEF   = 1000;
    localparam int REPEAT_CYCLES_DEF = 0;
    localparam bit ACTIVE_LOW_DEF    = 1'b0;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_HOLD   = 2'd1,
        PH_REPEAT = 2'd2
    } phase_e;

    // Ceiling log2, usable in constant expressions for counter widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_edge_chan.sv
// rtl/btn_edge_chan.sv - one channel: synchroniser, debounce and long-press/repeat FSM
module btn_edge_chan
    import btn_edge_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter bit ACTIVE_LOW    = ACTIVE_LOW_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn,
    output logic level,
    output logic pos_flag,
    output logic neg_flag,
    output logic long_flag
);

    localparam int DW = clog2(DB_CYCLES + 1);
    localparam int HW = clog2(max2(LONG_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic                   btn_norm;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DW-1:0]          db_cnt;
    logic [HW-1:0]          hold_cnt;
    phase_e                 phase;
    logic                   accept;
    logic                   rise_evt;
    logic                   fall_evt;

    // Polarity is normalised before the synchroniser so "pressed" is always 1.
    assign btn_norm = ACTIVE_LOW ? ~btn : btn;
    assign sync     = sync_q[SYNC_STAGES-1];

    // A new level is accepted on the DB_CYCLES-th consecutive mismatching sample.
    assign accept   = (sync != level) && (db_cnt == DB_LAST);
    assign rise_evt = accept && !level;
    assign fall_evt = accept && level;

    // Metastability synchroniser: shift the normalised input through SYNC_STAGES flops.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_norm};
        end
    end

    // Debounce: count consecutive mismatches, any matching sample restarts the count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level    <= 1'b0;
            db_cnt   <= '0;
            pos_flag <= 1'b0;
            neg_flag <= 1'b0;
        end else begin
            pos_flag <= 1'b0;
            neg_flag <= 1'b0;
            if (sync == level) begin
                db_cnt <= '0;
            end else if (accept) begin
                level    <= sync;
                db_cnt   <= '0;
                pos_flag <= sync;
                neg_flag <= ~sync;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Long-press FSM: first pulse after LONG_CYCLES, then every REPEAT_CYCLES (0 = saturate).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase     <= PH_IDLE;
            hold_cnt  <= '0;
            long_flag <= 1'b0;
        end else begin
            long_flag <= 1'b0;
            if (fall_evt) begin
                phase    <= PH_IDLE;
                hold_cnt <= '0;
            end else begin
                case (phase)
                    PH_IDLE: begin
                        hold_cnt <= '0;
                        if (rise_evt) begin
                            phase <= PH_HOLD;
                        end
                    end
                    PH_HOLD: begin
                        if (hold_cnt == LONG_LAST) begin
                            long_flag <= 1'b1;
                            phase     <= PH_REPEAT;
                            hold_cnt  <= (REPEAT_CYCLES > 0) ? '0 : LONG_SAT;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    PH_REPEAT: begin
                        if (REPEAT_CYCLES > 0) begin
                            if (hold_cnt == REP_LAST) begin
                                long_flag <= 1'b1;
                                hold_cnt  <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                        end
                    end
                    default: begin
                        phase    <= PH_IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_edge_det_n.sv
// rtl/btn_edge_det_n.sv - multi-channel debounced button edge and long-press detector
module btn_edge_det_n
    import btn_edge_pkg::*;
#(
    parameter int CH_NUM        = CH_NUM_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter bit ACTIVE_LOW    = ACTIVE_LOW_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [CH_NUM-1:0] i_btn,
    output logic [CH_NUM-1:0] o_level,
    output logic [CH_NUM-1:0] posedge_flag,
    output logic [CH_NUM-1:0] negedge_flag,
    output logic [CH_NUM-1:0] long_flag
);

    // Channels are fully independent copies.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        btn_edge_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_chan (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .btn       (i_btn[g]),
            .level     (o_level[g]),
            .pos_flag  (posedge_flag[g]),
            .neg_flag  (negedge_flag[g]),
            .long_flag (long_flag[g])
        );
    end

endmodule

// File: tb/tb_btn_edge_det_n.sv
// tb/tb_btn_edge_det_n.sv - self-checking bench for btn_edge_det_n
module tb_btn_edge_det_n;

    localparam int SS = 2;
    localparam int DB = 4;
    localparam int LC = 16;
    localparam int RC = 8;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [3:0] btn_a     = 4'hF;
    logic [3:0] btn_b     = 4'hF;
    logic [3:0] lvl_a, pos_a, neg_a, lng_a;
    logic [3:0] lvl_b, pos_b, neg_b, lng_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state: virtual channels 0-3 are dut_a, 4-7 are dut_b (pressed = 1).
    int  cyc   = 0;
    int  epoch = 1;
    bit  raw_log [8][0:4095];
    bit  mlevel  [8];
    int  last_flip [8];
    int  press_t [8];
    bit  e_pos [8];
    bit  e_neg [8];
    bit  e_long [8];

    int cnt_pos [8];
    int cnt_neg [8];
    int cnt_long [8];
    int first_pos_t [8];
    int first_long_t [8];
    int long_log2 [$];

    int k;
    int p;
    int dur [8];
    bit val [8];

    btn_edge_det_n #(
        .CH_NUM(4), .SYNC_STAGES(SS), .DB_CYCLES(DB),
        .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_btn(btn_a),
        .o_level(lvl_a), .posedge_flag(pos_a), .negedge_flag(neg_a), .long_flag(lng_a)
    );

    btn_edge_det_n #(
        .CH_NUM(4), .SYNC_STAGES(SS), .DB_CYCLES(DB),
        .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_btn(btn_b),
        .o_level(lvl_b), .posedge_flag(pos_b), .negedge_flag(neg_b), .long_flag(lng_b)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample a channel saw at edge t: input captured SS edges earlier, zero from cleared stages.
    function automatic bit seen(input int c, input int t);
        if (t - SS < epoch) return 1'b0;
        return raw_log[c][t-SS];
    endfunction

    task automatic clr_ev();
        for (int c = 0; c < 8; c++) begin
            cnt_pos[c] = 0; cnt_neg[c] = 0; cnt_long[c] = 0;
            first_pos_t[c] = -1; first_long_t[c] = -1;
        end
        long_log2.delete();
    endtask

    task automatic step();
        logic [3:0] x_lvl_a, x_pos_a, x_neg_a, x_lng_a;
        logic [3:0] x_lvl_b, x_pos_b, x_neg_b, x_lng_b;
        @(posedge sys_clk);
        cyc++;
        for (int c = 0; c < 8; c++) begin
            e_pos[c] = 1'b0; e_neg[c] = 1'b0; e_long[c] = 1'b0;
        end
        if (!sys_rst_n) begin
            epoch = cyc + 1;
            for (int c = 0; c < 8; c++) begin
                mlevel[c] = 1'b0; last_flip[c] = -1; press_t[c] = 0;
            end
        end else begin
            for (int c = 0; c < 8; c++) begin
                int idx;
                int since;
                bit flip;
                idx = c % 4;
                raw_log[c][cyc] = (c < 4) ? btn_a[idx[1:0]] : ~btn_b[idx[1:0]];
                since = (last_flip[c] + 1 > epoch) ? last_flip[c] + 1 : epoch;
                flip = 1'b0;
                if (cyc - DB + 1 >= since) begin
                    flip = 1'b1;
                    for (int j = 0; j < DB; j++) begin
                        if (seen(c, cyc - j) == mlevel[c]) flip = 1'b0;
                    end
                end
                if (flip) begin
                    e_pos[c] = !mlevel[c];
                    e_neg[c] = mlevel[c];
                    mlevel[c] = !mlevel[c];
                    last_flip[c] = cyc;
                    if (mlevel[c]) press_t[c] = cyc;
                end else if (mlevel[c] && (cyc - press_t[c] >= LC) &&
                             ((cyc - press_t[c] - LC) % RC == 0)) begin
                    e_long[c] = 1'b1;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            x_lvl_a[c] = mlevel[c];   x_pos_a[c] = e_pos[c];
            x_neg_a[c] = e_neg[c];    x_lng_a[c] = e_long[c];
            x_lvl_b[c] = mlevel[c+4]; x_pos_b[c] = e_pos[c+4];
            x_neg_b[c] = e_neg[c+4];  x_lng_b[c] = e_long[c+4];
        end
        @(negedge sys_clk);
        chk("level_a", lvl_a, x_lvl_a);
        chk("pos_a",   pos_a, x_pos_a);
        chk("neg_a",   neg_a, x_neg_a);
        chk("long_a",  lng_a, x_lng_a);
        chk("level_b", lvl_b, x_lvl_b);
        chk("pos_b",   pos_b, x_pos_b);
        chk("neg_b",   neg_b, x_neg_b);
        chk("long_b",  lng_b, x_lng_b);
        for (int c = 0; c < 8; c++) begin
            int idx;
            logic op, on, ol;
            idx = c % 4;
            op = (c < 4) ? pos_a[idx[1:0]] : pos_b[idx[1:0]];
            on = (c < 4) ? neg_a[idx[1:0]] : neg_b[idx[1:0]];
            ol = (c < 4) ? lng_a[idx[1:0]] : lng_b[idx[1:0]];
            if (op === 1'b1) begin
                if (cnt_pos[c] == 0) first_pos_t[c] = cyc;
                cnt_pos[c]++;
            end
            if (on === 1'b1) cnt_neg[c]++;
            if (ol === 1'b1) begin
                if (cnt_long[c] == 0) first_long_t[c] = cyc;
                cnt_long[c]++;
                if (c == 2) long_log2.push_back(cyc);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int c = 0; c < 8; c++) begin
            mlevel[c] = 1'b0; last_flip[c] = -1; press_t[c] = 0; dur[c] = 0; val[c] = 1'b0;
        end
        clr_ev();

        // Reset with all buttons high: outputs clear asynchronously and stay clear.
        #1 sys_rst_n = 1'b0;
        #1;
        chk("rst_async_level", {lvl_a, lvl_b}, 8'h00);
        chk("rst_async_flags", {pos_a, neg_a, lng_a, pos_b, neg_b, lng_b}, 24'h0);
        run(2);
        sys_rst_n = 1'b1;
        btn_a = 4'h0;
        run(10);

        // Clean press on channel 0.
        clr_ev();
        btn_a[0] = 1'b1;
        k = cyc + 1;
        run(20);
        chk("clean_pos_time", first_pos_t[0], k + SS + DB - 1);
        chk("clean_pos_count", cnt_pos[0], 1);
        chk("clean_quiet", cnt_pos[1] + cnt_pos[2] + cnt_pos[3] + cnt_neg[1] + cnt_neg[2] + cnt_neg[3], 0);
        btn_a[0] = 1'b0;
        run(12);
        chk("clean_neg_count", cnt_neg[0], 1);

        // Bounce on channel 1: 3-cycle high bursts never reach DB samples.
        clr_ev();
        for (int i = 0; i < 40; i++) begin
            btn_a[1] = ((i % 4) != 3);
            step();
        end
        chk("bounce_no_pos", cnt_pos[1], 0);
        chk("bounce_no_neg", cnt_neg[1], 0);
        btn_a[1] = 1'b1;
        run(20);
        chk("bounce_then_steady", cnt_pos[1], 1);
        btn_a[1] = 1'b0;
        run(10);

        // Long press with auto-repeat on channel 2.
        clr_ev();
        btn_a[2] = 1'b1;
        run(SS + DB);
        p = cyc;
        chk("long_press_accept", first_pos_t[2], p);
        run(50);
        btn_a[2] = 1'b0;
        run(20);
        chk("long_count", cnt_long[2], 5);
        for (int i = 0; i < 5; i++) begin
            if (i < long_log2.size()) chk("long_offset", long_log2[i] - p, LC + RC * i);
        end
        chk("long_release_neg", cnt_neg[2], 1);

        // Active-low instance: all four pressed in the same cycle.
        clr_ev();
        btn_b = 4'h0;
        k = cyc + 1;
        run(10);
        for (int c = 4; c < 8; c++) chk("simul_pos_time", first_pos_t[c], k + SS + DB - 1);
        chk("simul_no_neg", cnt_neg[4] + cnt_neg[5] + cnt_neg[6] + cnt_neg[7], 0);
        btn_b = 4'hF;
        run(10);

        // Reset in the middle of a hold on channel 3.
        clr_ev();
        btn_a[3] = 1'b1;
        run(SS + DB + 10);
        sys_rst_n = 1'b0;
        #1;
        chk("midhold_rst_level", lvl_a, 4'h0);
        chk("midhold_rst_flags", {pos_a, neg_a, lng_a}, 12'h0);
        step();
        sys_rst_n = 1'b1;
        clr_ev();
        k = cyc + 1;
        run(30);
        chk("midhold_repress", first_pos_t[3], k + SS + DB - 1);
        chk("midhold_long", first_long_t[3], k + SS + DB - 1 + LC);
        btn_a[3] = 1'b0;
        run(10);

        // Randomised mix of short bounces and long holds on every channel of both instances.
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < 8; c++) begin
                if (dur[c] == 0) begin
                    val[c] = 1'($urandom_range(0, 1));
                    dur[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 6));
                end
                dur[c]--;
            end
            btn_a = {val[3], val[2], val[1], val[0]};
            btn_b = {val[7], val[6], val[5], val[4]};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_edge_det_n.md
# btn_edge_det_n

Multi-channel, parametrised successor to the single-button edge detector. Each of `CH_NUM` raw button/switch inputs is synchronised, debounced and converted into a stable level plus one-cycle rising/falling-edge pulses. A long-press pulse with optional auto-repeat is also generated. Sits between board-level push-buttons and the control FSMs of lab designs, so downstream logic never sees metastable or bouncing inputs.

## Interface
- `CH_NUM`, 4: number of independent channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flip-flop depth, ≥2.
- `DB_CYCLES`, 20: consecutive mismatching samples needed to accept a new level, ≥1.
- `LONG_CYCLES`, 1000: cycles the debounced level must stay 1 before the long-press pulse, ≥1.
- `REPEAT_CYCLES`, 0: auto-repeat period after long press; 0 disables repeat.
- `ACTIVE_LOW`, 0: 1 inverts `i_btn` before synchronisation, so a pressed button reads as 1.
- `sys_clk`  in  1  single system clock; all logic runs on its rising edge.
- `sys_rst_n`  in  1  reset, asynchronous and active-low.
- `i_btn`  in  CH_NUM  raw asynchronous inputs, one bit per channel.
- `o_level`  out  CH_NUM  debounced stable level per channel.
- `posedge_flag`  out  CH_NUM  one-cycle pulse when `o_level` goes 0→1.
- `negedge_flag`  out  CH_NUM  one-cycle pulse when `o_level` goes 1→0.
- `long_flag`  out  CH_NUM  one-cycle pulse on long press and on each auto-repeat.

## Operation
- Reset, while `sys_rst_n`=0 and independent of clock:
  - All synchroniser stages clear to 0.
  - All counters clear to 0.
  - `o_level`, `posedge_flag`, `negedge_flag` and `long_flag` are all 0.
- Channels are fully independent; no cross-channel interaction.
- Synchroniser: `s = ACTIVE_LOW ? ~i_btn : i_btn` is shifted through `SYNC_STAGES` registers. `sync` is the last stage.
- Debounce per channel uses counter `db_cnt`, width `$clog2(DB_CYCLES+1)`. At each edge:
  - If `sync == o_level`: `db_cnt <= 0`.
  - Else if `db_cnt == DB_CYCLES-1`: `o_level <= sync`, `db_cnt <= 0`, and assert `posedge_flag` or `negedge_flag` for exactly one cycle, matching the new level.
  - Else: `db_cnt <= db_cnt+1`.
- Glitch rejection: a mismatch lasting fewer than `DB_CYCLES` synchronised samples produces no level change and no pulse. A single matching sample restarts the count from 0.
- Long press per channel uses counter `hold_cnt`, width `$clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1)`. Per cycle:
  - While `o_level`=0: `hold_cnt` = 0.
  - While `o_level`=1, counting phase: `hold_cnt` increments each cycle. When it reaches `LONG_CYCLES`, pulse `long_flag` for one cycle.
  - After that pulse, `REPEAT_CYCLES`=0: the counter saturates and there are no further pulses until release.
  - After that pulse, `REPEAT_CYCLES`>0: the counter reloads to 0 in repeat phase and pulses `long_flag` every `REPEAT_CYCLES` cycles while the level stays 1.
  - A falling `o_level` clears `hold_cnt` and the phase in the same cycle as `negedge_flag`.
- Simultaneous events:
  - `posedge_flag` and `negedge_flag` are never high together on one channel.
  - `long_flag` is never high in the same cycle as `posedge_flag`, because `LONG_CYCLES` ≥1.
- Reset mid-debounce or mid-hold discards all progress. After release, a held-high input is re-detected as a fresh rising edge after the full latency.

## Timing
- Rising-edge latency: raw input first sampled at edge k gives `posedge_flag`/`o_level` high after edge k+SYNC_STAGES+DB_CYCLES-1. Falling edges behave symmetrically.
- The `long_flag` pulse follows `posedge_flag` by exactly `LONG_CYCLES` cycles.
- Each repeat pulse follows the previous `long_flag` pulse by `REPEAT_CYCLES` cycles.
- All outputs are registered; there is no combinational path from `i_btn`.
- Pulse width is always exactly one `sys_clk` cycle.

## Structure
- Shared package/header `btn_edge_pkg` holds:
  - Parameter defaults.
  - A `CLOG2` helper macro or function for counter widths.
  - Phase encoding: `PH_IDLE`=0, `PH_HOLD`=1, `PH_REPEAT`=2.
- Sub-module `btn_edge_chan` implements one channel:
  - Synchroniser.
  - Debounce counter.
  - Hold counter/phase FSM.
- The top module instantiates `btn_edge_chan` `CH_NUM` times in a generate loop.

## Test plan
All scenarios use `CH_NUM`=4, `SYNC_STAGES`=2, `DB_CYCLES`=4, `LONG_CYCLES`=16, `REPEAT_CYCLES`=8, and a 10 ns clock.
- Reset check: hold `sys_rst_n`=0 for 20 ns with `i_btn`=4'hF → all outputs are 0 throughout reset.
- Clean press: `i_btn[0]` 0→1, first sampled at edge k → `posedge_flag[0]` pulses for one cycle after edge k+5 and `o_level[0]`=1. Channels 1–3 stay quiet.
- Bounce rejection: `i_btn[1]` toggles with 3-cycle high bursts for 40 cycles → no flags and `o_level[1]` stays 0. It then goes steady high → exactly one `posedge_flag[1]`.
- Long press with repeat: hold `i_btn[2]` for 50 cycles after acceptance → `long_flag[2]` at +16, +24, +32, +40 and +48 cycles after `posedge_flag[2]`. Release → one `negedge_flag[2]` and no further `long_flag`.
- Simultaneous channels with `ACTIVE_LOW`=1: drive `i_btn`=4'hF→4'h0 in one cycle → all four `posedge_flag` bits pulse together in one cycle, and `negedge_flag`=0.
- Reset mid-hold: assert `sys_rst_n`=0 at +10 cycles of a hold, then release it with the input still high → outputs clear immediately. A fresh `posedge_flag` follows 6 cycles after reset release, and `long_flag` comes 16 cycles after that.
